tilelink_ul_responder: RTL and testbench

Parametrised TileLink-UL/UH slave responder for formal and simulation harnesses: it sits on the core's master A/D port in place of real memory. It queues up to `DEPTH` requests and answers each in order with the correct D opcode and beat count. It supports multi-beat Get and Put, and flags unsupported or oversized requests with `d_error`. Response data and back-pressure come from harness inputs, so the solver controls them as free variables.

---
 rtl/tl_ul_pkg.sv | 39 +++
 rtl/tl_req_fifo.sv | 58 +++++
 rtl/tilelink_ul_responder.sv | 150 +++++++++++++++
 tb/tb_tilelink_ul_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL/UH definitions for the responder: opcodes, queued request
// entry layout and the beats-per-message helper.
package tl_ul_pkg;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_ARITH       = 3'd2,
    A_LOGICAL     = 3'd3,
    A_GET         = 3'd4,
    A_INTENT      = 3'd5
  } a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2
  } d_opcode_e;

  // Entry fields are sized for the widest supported configuration
  // (SIZE_W <= 8, SOURCE_W <= 16, ADDR_W <= 64); unused upper bits stay zero.
  typedef struct packed {
    logic [2:0]  opcode;
    logic [7:0]  size;
    logic [15:0] source;
    logic [63:0] address;
  } req_t;

  function automatic int unsigned beats(input int unsigned size, input int unsigned lane_w);
    if (size <= lane_w) return 32'd1;
    if (size - lane_w >= 32'd31) return 32'h8000_0000;
    return 32'd1 << (size - lane_w);
  endfunction

  function automatic logic is_put(input logic [2:0] opcode);
    return (opcode == A_PUT_FULL) || (opcode == A_PUT_PARTIAL);
  endfunction

endpackage

// File: rtl/tl_req_fifo.sv
// In-order request queue; a push is accepted while full if the head pops in
// the same cycle.
module tl_req_fifo
  import tl_ul_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  req_t             push_data,
  input  logic             pop,
  output req_t             pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tilelink_ul_responder.sv
// TileLink-UL/UH slave stand-in: queues requests and answers them in order,
// with response data and back-pressure supplied by harness inputs.
module tilelink_ul_responder
  import tl_ul_pkg::*;
#(
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned ADDR_W    = 32,
  parameter  int unsigned SIZE_W    = 4,
  parameter  int unsigned SOURCE_W  = 1,
  parameter  int unsigned DEPTH     = 2,
  parameter  int unsigned MAX_SIZE  = 6,
  localparam int unsigned LANE_W    = $clog2(DATA_W / 8),
  localparam int unsigned ADDR_LO_W = (LANE_W > 0) ? LANE_W : 1,
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall_a,
  input  logic                  stall_d,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [2:0]            a_opcode,
  input  logic [2:0]            a_param,
  input  logic [SIZE_W-1:0]     a_size,
  input  logic [SOURCE_W-1:0]   a_source,
  input  logic [ADDR_W-1:0]     a_address,
  input  logic [DATA_W/8-1:0]   a_mask,
  input  logic [DATA_W-1:0]     a_data,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic [2:0]            d_opcode,
  output logic [1:0]            d_param,
  output logic [SIZE_W-1:0]     d_size,
  output logic [SOURCE_W-1:0]   d_source,
  output logic                  d_sink,
  output logic [ADDR_LO_W-1:0]  d_addr_lo,
  output logic [DATA_W-1:0]     d_data,
  output logic                  d_error,
  output logic [CNT_W-1:0]      outstanding
);

  req_t        push_entry;
  req_t        head;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        a_fire;
  logic        a_last;
  logic        d_fire;
  logic        d_last;
  logic [31:0] a_beat;
  logic [31:0] d_beat;
  logic [31:0] a_beats_n;
  logic [31:0] resp_beats;
  d_opcode_e   resp_opcode;
  logic        resp_error;
  logic        resp_data;
  logic        unused_ok;

  assign a_beats_n = is_put(a_opcode) ? beats(32'(a_size), LANE_W) : 32'd1;
  assign a_last    = (a_beat == a_beats_n - 32'd1);
  assign a_ready   = !reset && !stall_a && (!full || pop);
  assign a_fire    = a_valid && a_ready;
  assign push      = a_fire && a_last;

  assign d_valid   = !reset && !stall_d && !empty;
  assign d_fire    = d_valid && d_ready;
  assign d_last    = (d_beat == resp_beats - 32'd1);
  assign pop       = d_fire && d_last;

  assign unused_ok = ^{a_mask, a_param, a_data, head};

  always_comb begin
    push_entry                       = '0;
    push_entry.opcode                = a_opcode;
    push_entry.size[SIZE_W-1:0]      = a_size;
    push_entry.source[SOURCE_W-1:0]  = a_source;
    push_entry.address[ADDR_W-1:0]   = a_address;
  end

  tl_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty),
    .count    (outstanding)
  );

  // Oversized requests keep their normal opcode and beat count; only d_error marks them.
  always_comb begin
    resp_opcode = D_ACCESS_ACK;
    resp_beats  = 32'd1;
    resp_error  = (head.size > 8'(MAX_SIZE));
    resp_data   = 1'b0;
    case (head.opcode)
      A_GET: begin
        resp_opcode = D_ACCESS_ACK_DATA;
        resp_beats  = beats(32'(head.size), LANE_W);
        resp_data   = 1'b1;
      end
      A_ARITH, A_LOGICAL: begin
        resp_opcode = D_ACCESS_ACK_DATA;
        resp_beats  = beats(32'(head.size), LANE_W);
        resp_data   = 1'b1;
        resp_error  = 1'b1;
      end
      A_PUT_FULL, A_PUT_PARTIAL: resp_opcode = D_ACCESS_ACK;
      A_INTENT:                  resp_opcode = D_HINT_ACK;
      default:                   resp_error  = 1'b1;
    endcase
  end

  always_comb begin
    d_opcode  = '0;
    d_param   = '0;
    d_size    = '0;
    d_source  = '0;
    d_sink    = 1'b0;
    d_addr_lo = '0;
    d_data    = '0;
    d_error   = 1'b0;
    if (d_valid) begin
      d_opcode  = resp_opcode;
      d_size    = head.size[SIZE_W-1:0];
      d_source  = head.source[SOURCE_W-1:0];
      d_addr_lo = (LANE_W > 0) ? head.address[ADDR_LO_W-1:0] : '0;
      d_data    = resp_data ? rdata : '0;
      d_error   = resp_error;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_beat <= '0;
      d_beat <= '0;
    end else begin
      if (a_fire) a_beat <= a_last ? '0 : a_beat + 32'd1;
      if (d_fire) d_beat <= d_last ? '0 : d_beat + 32'd1;
    end
  end

endmodule

// File: tb/tb_tilelink_ul_responder.sv
// Directed bench for tilelink_ul_responder (DATA_W 32, DEPTH 2, SOURCE_W 2).
module tb_tilelink_ul_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_a;
  logic        stall_d;
  logic [31:0] rdata;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [3:0]  a_size;
  logic [1:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [1:0]  d_source;
  logic        d_sink;
  logic [1:0]  d_addr_lo;
  logic [31:0] d_data;
  logic        d_error;
  logic [1:0]  outstanding;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  tilelink_ul_responder #(
    .DATA_W(32), .ADDR_W(32), .SIZE_W(4), .SOURCE_W(2), .DEPTH(2), .MAX_SIZE(6)
  ) dut (
    .clock(clock), .reset(reset), .stall_a(stall_a), .stall_d(stall_d), .rdata(rdata),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
    .d_param(d_param), .d_size(d_size), .d_source(d_source), .d_sink(d_sink),
    .d_addr_lo(d_addr_lo), .d_data(d_data), .d_error(d_error), .outstanding(outstanding)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic drive_a(input logic v, input logic [2:0] op, input logic [3:0] sz,
                         input logic [1:0] src, input logic [31:0] addr);
    a_valid   = v;
    a_opcode  = op;
    a_size    = sz;
    a_source  = src;
    a_address = addr;
    a_param   = 3'd0;
    a_mask    = 4'hF;
    a_data    = $urandom;
  endtask

  initial begin
    reset = 1'b1; stall_a = 1'b0; stall_d = 1'b0; d_ready = 1'b0;
    rdata = 32'hDEAD_BEEF;
    drive_a(1'b1, 3'd4, 4'd2, 2'd1, 32'h0);
    smp();
    check("rst_a_ready", a_ready, 0);
    check("rst_d_valid", d_valid, 0);
    check("rst_d_opcode", d_opcode, 0);
    check("rst_d_data", d_data, 0);
    check("rst_d_fields", {d_size, d_source, d_addr_lo, d_error}, 0);
    check("rst_outstanding", outstanding, 0);
    cyc(); cyc();
    cyc(); reset = 1'b0; drive_a(1'b0, 3'd4, 4'd2, 2'd1, 32'h0); d_ready = 1'b1;
    smp();
    check("post_rst_d_valid", d_valid, 0);
    check("post_rst_outstanding", outstanding, 0);
    check("post_rst_a_ready", a_ready, 1);

    // Single-beat Get
    cyc(); drive_a(1'b1, 3'd4, 4'd2, 2'd1, 32'h1006); rdata = 32'hA5A5_0001;
    smp();
    check("get1_a_ready", a_ready, 1);
    check("get1_no_bypass", d_valid, 0);
    cyc(); drive_a(1'b0, 3'd0, 4'd0, 2'd0, 32'h0);
    smp();
    check("get1_d_valid", d_valid, 1);
    check("get1_d_opcode", d_opcode, 1);
    check("get1_d_data", d_data, 32'hA5A5_0001);
    check("get1_d_error", d_error, 0);
    check("get1_d_source", d_source, 1);
    check("get1_d_size", d_size, 2);
    check("get1_d_addr_lo", d_addr_lo, 2);
    check("get1_param_sink", {d_param, d_sink}, 0);
    check("get1_outstanding", outstanding, 1);
    cyc(); smp();
    check("get1_done_valid", d_valid, 0);
    check("get1_done_outstanding", outstanding, 0);

    // Four-beat Get with an initial D stall
    cyc(); drive_a(1'b1, 3'd4, 4'd4, 2'd2, 32'h20);
    smp();
    check("get4_a_ready", a_ready, 1);
    cyc(); drive_a(1'b0, 3'd0, 4'd0, 2'd0, 32'h0); d_ready = 1'b0; rdata = 32'h1111_0000;
    smp();
    check("get4_hold_valid", d_valid, 1);
    check("get4_hold_data", d_data, 32'h1111_0000);
    cyc(); smp();
    check("get4_hold_stable", {d_valid, d_opcode, d_size, d_source}, {1'b1, 3'd1, 4'd4, 2'd2});
    check("get4_hold_outstanding", outstanding, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(); d_ready = 1'b1; rdata = 32'h2222_0000 + i;
      smp();
      check("get4_beat_valid", d_valid, 1);
      check("get4_beat_data", d_data, 32'h2222_0000 + i);
      check("get4_beat_outstanding", outstanding, 1);
      check("get4_a_ready_high", a_ready, 1);
    end
    cyc(); smp();
    check("get4_done_valid", d_valid, 0);
    check("get4_done_outstanding", outstanding, 0);

    // Two-beat PutFull
    cyc(); drive_a(1'b1, 3'd0, 4'd3, 2'd3, 32'h40);
    smp();
    check("put_beat1_a_ready", a_ready, 1);
    cyc(); smp();
    check("put_no_d_before_last", d_valid, 0);
    check("put_mid_outstanding", outstanding, 0);
    check("put_beat2_a_ready", a_ready, 1);
    cyc(); drive_a(1'b0, 3'd0, 4'd0, 2'd0, 32'h0);
    smp();
    check("put_ack", {d_valid, d_opcode, d_error, d_size, d_source}, {1'b1, 3'd0, 1'b0, 4'd3, 2'd3});
    check("put_ack_data_zero", d_data, 0);
    check("put_outstanding", outstanding, 1);
    cyc(); smp();
    check("put_done_valid", d_valid, 0);

    // Three Gets into a two-entry queue while D is blocked
    d_ready = 1'b0;
    cyc(); drive_a(1'b1, 3'd4, 4'd2, 2'd1, 32'h101);
    smp();
    check("q_g1_a_ready", a_ready, 1);
    cyc(); drive_a(1'b1, 3'd4, 4'd2, 2'd2, 32'h106);
    smp();
    check("q_g2_a_ready", a_ready, 1);
    check("q_g2_head_src", d_source, 1);
    cyc(); drive_a(1'b1, 3'd4, 4'd2, 2'd3, 32'h10B);
    smp();
    check("q_full_a_ready", a_ready, 0);
    check("q_full_outstanding", outstanding, 2);
    cyc(); smp();
    check("q_full_hold", a_ready, 0);
    cyc(); d_ready = 1'b1;
    smp();
    check("q_pop_accept", a_ready, 1);
    check("q_pop_head_src", d_source, 1);
    check("q_pop_outstanding", outstanding, 2);
    cyc(); drive_a(1'b0, 3'd0, 4'd0, 2'd0, 32'h0);
    smp();
    check("q_second", {d_valid, d_source, d_addr_lo}, {1'b1, 2'd2, 2'd2});
    check("q_second_outstanding", outstanding, 2);
    cyc(); smp();
    check("q_third", {d_valid, d_source, d_addr_lo}, {1'b1, 2'd3, 2'd3});
    check("q_third_outstanding", outstanding, 1);
    cyc(); smp();
    check("q_drained", {d_valid, outstanding}, 0);

    // Oversized Get followed by opcode 6
    cyc(); drive_a(1'b1, 3'd4, 4'd7, 2'd1, 32'h200);
    smp();
    check("big_a_ready", a_ready, 1);
    cyc(); drive_a(1'b1, 3'd6, 4'd2, 2'd2, 32'h300);
    smp();
    check("op6_a_ready", a_ready, 1);
    check("big_first", {d_valid, d_opcode, d_error, d_size, d_source}, {1'b1, 3'd1, 1'b1, 4'd7, 2'd1});
    for (int i = 1; i < 32; i++) begin
      cyc(); drive_a(1'b0, 3'd0, 4'd0, 2'd0, 32'h0);
      smp();
      check("big_beat", {d_valid, d_opcode, d_error, d_source}, {1'b1, 3'd1, 1'b1, 2'd1});
    end
    cyc(); smp();
    check("op6_ack", {d_valid, d_opcode, d_error, d_size, d_source}, {1'b1, 3'd0, 1'b1, 4'd2, 2'd2});
    check("op6_outstanding", outstanding, 1);
    cyc(); smp();
    check("op6_done", d_valid, 0);

    // Arithmetic and Intent
    cyc(); drive_a(1'b1, 3'd2, 4'd2, 2'd0, 32'h0); rdata = 32'h3333_0000;
    smp();
    cyc(); drive_a(1'b0, 3'd0, 4'd0, 2'd0, 32'h0);
    smp();
    check("arith_ack", {d_valid, d_opcode, d_error}, {1'b1, 3'd1, 1'b1});
    check("arith_data", d_data, 32'h3333_0000);
    cyc(); drive_a(1'b1, 3'd5, 4'd6, 2'd1, 32'h0);
    smp();
    cyc(); drive_a(1'b0, 3'd0, 4'd0, 2'd0, 32'h0);
    smp();
    check("intent_ack", {d_valid, d_opcode, d_error, d_size}, {1'b1, 3'd2, 1'b0, 4'd6});
    check("intent_data_zero", d_data, 0);
    cyc(); stall_a = 1'b1;
    smp();
    check("stall_a_ready", a_ready, 0);
    cyc(); stall_a = 1'b0;

    // Reset in the middle of a four-beat Get
    cyc(); drive_a(1'b1, 3'd4, 4'd4, 2'd0, 32'h400);
    smp();
    cyc(); drive_a(1'b0, 3'd0, 4'd0, 2'd0, 32'h0);
    smp();
    check("mid_beat1_valid", d_valid, 1);
    cyc(); reset = 1'b1;
    smp();
    check("mid_rst_valid", d_valid, 0);
    cyc(); reset = 1'b0;
    smp();
    check("after_rst", {d_valid, outstanding}, 0);
    cyc(); drive_a(1'b1, 3'd4, 4'd2, 2'd1, 32'h501); rdata = 32'hCAFE_0001;
    smp();
    check("fresh_a_ready", a_ready, 1);
    cyc(); drive_a(1'b0, 3'd0, 4'd0, 2'd0, 32'h0);
    smp();
    check("fresh_resp", {d_valid, d_opcode, d_source, d_addr_lo, outstanding},
          {1'b1, 3'd1, 2'd1, 2'd1, 2'd1});
    check("fresh_data", d_data, 32'hCAFE_0001);
    cyc(); smp();
    check("fresh_done", {d_valid, outstanding}, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
